piece_position_ctrl: RTL and testbench
======================================

Name: piece_position_ctrl

Overview:
- Holds the falling Tetris piece's cell coordinates.
- Accepts candidate positions from the move/rotate logic through a valid/ready handshake.
- Legality-checks every candidate against board bounds and the playfield occupancy map. Commits legal candidates and rejects the rest.
- Generates the lock ("placed") event after repeated failed down-moves, and the game-over event on a blocked spawn.
- Sits between the move generator and the playfield/line-clear logic.

Parameters:
- X_W, 3, width of one x coordinate
- Y_W, 4, width of one y coordinate
- BOARD_W, 8, playfield columns (legal x: 0..BOARD_W-1)
- BOARD_H, 16, playfield rows (legal y: 0..BOARD_H-1)
- CELLS, 4, cells per piece
- SPAWN_X, 2, reset x of cell 0; cell i resets to SPAWN_X+i, all y reset to 0
- LOCK_DELAY, 2, consecutive rejected down-moves required to lock (1..15)

Ports:
- CLK  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- spawn  input  1  request to load a new piece (honoured only in IDLE)
- spawn_x  input  CELLS*X_W  packed spawn x, cell i at [i*X_W +: X_W]
- spawn_y  input  CELLS*Y_W  packed spawn y, same packing
- cand_valid  input  1  candidate position offered
- cand_ready  output  1  candidate can be taken this cycle
- cand_x  input  CELLS*X_W  packed candidate x
- cand_y  input  CELLS*Y_W  packed candidate y
- cand_is_down  input  1  candidate is a gravity/soft-drop move
- board_occ  input  BOARD_W*BOARD_H  occupancy, bit y*BOARD_W+x
- cell_x  output  CELLS*X_W  current committed x
- cell_y  output  CELLS*Y_W  current committed y
- accept  output  1  one-cycle pulse: candidate/spawn committed
- reject  output  1  one-cycle pulse: candidate discarded
- placed  output  1  one-cycle pulse: piece locked
- game_over  output  1  sticky until reset
- active  output  1  a piece is live (ACTIVE or CHECK)

Behaviour:
- Reset (async, reset=0):
  - state IDLE; cell_x[i]=SPAWN_X+i, cell_y[i]=0.
  - accept, reject, placed, game_over = 0; lock counter = 0; candidate registers = 0.
  - Reset asserted mid-CHECK/SPCHK abandons the check with no pulse.
- States: IDLE, SPCHK, ACTIVE, CHECK, OVER.
- IDLE:
  - cand_ready=0.
  - spawn=1 registers spawn_x/spawn_y into the candidate register, lock counter cleared, goes to SPCHK.
- SPCHK (one cycle):
  - Legal: cell_x/cell_y load the candidate, accept pulses, goes to ACTIVE.
  - Illegal: cells unchanged, game_over set, goes to OVER.
- ACTIVE:
  - cand_ready=1.
  - cand_valid&cand_ready registers cand_x/cand_y/cand_is_down, goes to CHECK.
  - spawn is ignored.
- CHECK (one cycle, cand_ready=0):
  - Legal: cells commit, accept pulses. If cand_is_down, lock counter clears.
  - Illegal: cells hold, reject pulses. If cand_is_down, lock counter increments.
  - If the incremented count equals LOCK_DELAY: placed pulses in the same cycle as reject, counter clears, goes to IDLE.
  - Otherwise returns to ACTIVE.
  - An accepted lateral/rotate move leaves the counter unchanged.
- OVER: cand_ready=0; spawn and cand_valid are ignored until reset.
- Legality: the candidate is illegal if any cell has x>=BOARD_W, y>=BOARD_H, or board_occ[y*BOARD_W+x]=1.
  - Index arithmetic is done at width clog2(BOARD_W*BOARD_H)+1.
  - An out-of-range cell never indexes board_occ.
  - board_occ is sampled in the CHECK/SPCHK cycle, not at the handshake.
- Latency: handshake at edge T; cell outputs and the accept/reject pulse update at edge T+1; cand_ready is high again from T+1 when the block returns to ACTIVE. Maximum throughput is one candidate per two cycles.
- active=1 in ACTIVE and CHECK only.
- No simultaneous-event conflict exists: spawn is honoured only in IDLE, where cand_ready=0.

Optional Feature:
- Macro REJECT_REASON_EN.
- When defined, adds output reject_reason [1:0], valid while reject=1 and 0 otherwise:
  - bit0 = any cell out of bounds;
  - bit1 = any in-bounds cell hits an occupied square.
- On a failed spawn check (SPCHK to OVER), reject_reason holds the same encoding for that one cycle.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release -> cell_x={2,3,4,5}, cell_y all 0, all pulses 0, cand_ready=0, active=0.
- spawn x={2,3,4,5} y=0 on empty board -> accept one cycle later, active=1, cand_ready=1; then cand x={3,4,5,6} y=0 lateral -> accept at T+1, cell_x={3,4,5,6}.
- Candidate with cell x=8 (BOARD_W=8) -> reject, cells unchanged, reject_reason=01 if REJECT_REASON_EN is defined.
- board_occ bit 1*8+4 set, candidate with cell at (4,1) down -> reject, lock counter=1; a second identical request -> reject and placed in the same cycle, state IDLE, cand_ready=0.
- Down reject, then legal down accept, then down reject -> no placed pulse (counter was cleared by the accept).
- board_occ bit 0*8+3 set, spawn covering (3,0) -> game_over=1 and stays high; spawn and cand_valid ignored; reset=0 clears it.

Source files
------------

// File: rtl/piece_position_ctrl.sv
// Falling-piece position register with legality check, lock and game-over.
// Optional build macro REJECT_REASON_EN adds the reject_reason output.
//
// Ports:
//   CLK, reset            clock (rising), async active-low reset
//   spawn, spawn_x/_y     new-piece request and packed coordinates
//   cand_valid/_ready     candidate handshake
//   cand_x/_y, cand_is_down  packed candidate and gravity flag
//   board_occ             occupancy map, bit y*BOARD_W+x
//   cell_x, cell_y        committed packed coordinates
//   accept/reject/placed  one-cycle event pulses
//   game_over, active     sticky game-over, piece-live flag
//   reject_reason         {hit, out-of-bounds} (REJECT_REASON_EN only)
module piece_position_ctrl #(
  parameter int X_W        = 3,
  parameter int Y_W        = 4,
  parameter int BOARD_W    = 8,
  parameter int BOARD_H    = 16,
  parameter int CELLS      = 4,
  parameter int SPAWN_X    = 2,
  parameter int LOCK_DELAY = 2
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       spawn,
  input  logic [CELLS*X_W-1:0]       spawn_x,
  input  logic [CELLS*Y_W-1:0]       spawn_y,
  input  logic                       cand_valid,
  output logic                       cand_ready,
  input  logic [CELLS*X_W-1:0]       cand_x,
  input  logic [CELLS*Y_W-1:0]       cand_y,
  input  logic                       cand_is_down,
  input  logic [BOARD_W*BOARD_H-1:0] board_occ,
  output logic [CELLS*X_W-1:0]       cell_x,
  output logic [CELLS*Y_W-1:0]       cell_y,
  output logic                       accept,
  output logic                       reject,
  output logic                       placed,
  output logic                       game_over,
  output logic                       active
`ifdef REJECT_REASON_EN
  ,
  output logic [1:0]                 reject_reason
`endif
);

  localparam int NCELL = BOARD_W * BOARD_H;
  localparam int IW    = $clog2(NCELL) + 1;
  localparam int XS    = CELLS * X_W;
  localparam int YS    = CELLS * Y_W;

  function automatic logic [XS-1:0] spawn_init();
    logic [XS-1:0] v;
    v = '0;
    for (int i = 0; i < CELLS; i++)
      v[i*X_W +: X_W] = X_W'(SPAWN_X + i);
    return v;
  endfunction

  localparam logic [XS-1:0] CX_RST = spawn_init();

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPCHK,
    S_ACTIVE,
    S_CHECK,
    S_OVER
  } state_t;

  state_t state_q, state_d;

  logic [XS-1:0] cx_q, cx_d, px_q, px_d;
  logic [YS-1:0] cy_q, cy_d, py_q, py_d;
  logic          pdown_q, pdown_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          rej_q, rej_d;
  logic          plc_q, plc_d;
  logic          go_q, go_d;
  logic          oob_c, hit_c, legal_c, lock_c;

  // Out-of-range cells are screened before indexing the map.
  always_comb begin
    oob_c = 1'b0;
    hit_c = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      logic [IW-1:0] xe, ye, idx;
      xe  = IW'(px_q[i*X_W +: X_W]);
      ye  = IW'(py_q[i*Y_W +: Y_W]);
      idx = '0;
      if (xe >= IW'(BOARD_W) || ye >= IW'(BOARD_H)) begin
        oob_c = 1'b1;
      end else begin
        idx = ye * IW'(BOARD_W) + xe;
        if (board_occ[idx[IW-2:0]])
          hit_c = 1'b1;
      end
    end
    legal_c = !oob_c && !hit_c;
    lock_c  = !legal_c && pdown_q &&
              (cnt_q + 4'd1 == 4'(LOCK_DELAY));
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (spawn) state_d = S_SPCHK;
      S_SPCHK:  state_d = legal_c ? S_ACTIVE : S_OVER;
      S_ACTIVE: if (cand_valid) state_d = S_CHECK;
      S_CHECK:  state_d = lock_c ? S_IDLE : S_ACTIVE;
      S_OVER:   state_d = S_OVER;
      default:  state_d = S_IDLE;
    endcase
  end

`ifdef REJECT_REASON_EN
  logic [1:0] rsn_q, rsn_d;
`endif

  always_comb begin
    cx_d    = cx_q;
    cy_d    = cy_q;
    px_d    = px_q;
    py_d    = py_q;
    pdown_d = pdown_q;
    cnt_d   = cnt_q;
    acc_d   = 1'b0;
    rej_d   = 1'b0;
    plc_d   = 1'b0;
    go_d    = go_q;
`ifdef REJECT_REASON_EN
    rsn_d   = 2'b00;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (spawn) begin
          px_d  = spawn_x;
          py_d  = spawn_y;
          cnt_d = 4'd0;
        end
      end
      S_SPCHK: begin
        if (legal_c) begin
          cx_d  = px_q;
          cy_d  = py_q;
          acc_d = 1'b1;
        end else begin
          go_d  = 1'b1;
`ifdef REJECT_REASON_EN
          rsn_d = {hit_c, oob_c};
`endif
        end
      end
      S_ACTIVE: begin
        if (cand_valid) begin
          px_d    = cand_x;
          py_d    = cand_y;
          pdown_d = cand_is_down;
        end
      end
      S_CHECK: begin
        if (legal_c) begin
          cx_d  = px_q;
          cy_d  = py_q;
          acc_d = 1'b1;
          if (pdown_q) cnt_d = 4'd0;
        end else begin
          rej_d = 1'b1;
`ifdef REJECT_REASON_EN
          rsn_d = {hit_c, oob_c};
`endif
          if (lock_c) begin
            plc_d = 1'b1;
            cnt_d = 4'd0;
          end else if (pdown_q) begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_OVER: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cx_q    <= CX_RST;
      cy_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pdown_q <= 1'b0;
      cnt_q   <= 4'd0;
      acc_q   <= 1'b0;
      rej_q   <= 1'b0;
      plc_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pdown_q <= pdown_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rej_q   <= rej_d;
      plc_q   <= plc_d;
      go_q    <= go_d;
    end
  end

`ifdef REJECT_REASON_EN
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) rsn_q <= 2'b00;
    else        rsn_q <= rsn_d;
  end

  assign reject_reason = rsn_q;
`endif

  assign cand_ready = (state_q == S_ACTIVE);
  assign active     = (state_q == S_ACTIVE) ||
                      (state_q == S_CHECK);
  assign cell_x     = cx_q;
  assign cell_y     = cy_q;
  assign accept     = acc_q;
  assign reject     = rej_q;
  assign placed     = plc_q;
  assign game_over  = go_q;

endmodule

// File: tb/tb_piece_position_ctrl.sv
// Bench for piece_position_ctrl: directed scenarios plus random moves
// checked every cycle against a behavioural model of the piece.
module tb_piece_position_ctrl;

  localparam int XW = 4;
  localparam int YW = 5;
  localparam int BW = 8;
  localparam int BH = 16;
  localparam int LD = 2;

  logic         CLK = 1'b0;
  logic         reset;
  logic         spawn = 1'b0;
  logic [15:0]  spawn_x = '0;
  logic [19:0]  spawn_y = '0;
  logic         cand_valid = 1'b0;
  logic         cand_ready;
  logic [15:0]  cand_x = '0;
  logic [19:0]  cand_y = '0;
  logic         cand_is_down = 1'b0;
  logic [127:0] board_occ = '0;
  logic [15:0]  cell_x;
  logic [19:0]  cell_y;
  logic         accept, reject, placed, game_over, active;
`ifdef REJECT_REASON_EN
  logic [1:0]   reject_reason;
`endif

  piece_position_ctrl #(
    .X_W(XW), .Y_W(YW), .BOARD_W(BW), .BOARD_H(BH),
    .CELLS(4), .SPAWN_X(2), .LOCK_DELAY(LD)
  ) dut (
    .CLK(CLK), .reset(reset), .spawn(spawn),
    .spawn_x(spawn_x), .spawn_y(spawn_y),
    .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_x(cand_x), .cand_y(cand_y),
    .cand_is_down(cand_is_down), .board_occ(board_occ),
    .cell_x(cell_x), .cell_y(cell_y),
    .accept(accept), .reject(reject), .placed(placed),
    .game_over(game_over), .active(active)
`ifdef REJECT_REASON_EN
    , .reject_reason(reject_reason)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 spawn check, 2 live, 3 move check, 4 over
  int mode;
  int mx[4], my[4], px[4], py[4];
  bit pd;
  int fails;
  bit e_acc, e_rej, e_plc, e_go;
  int e_rsn;

  task automatic cmp(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, got, exp);
    end
  endtask

  // {hit, out-of-bounds} of a position against the board
  function automatic int why(int xs[4], int ys[4], logic [127:0] b);
    int r = 0;
    for (int i = 0; i < 4; i++) begin
      if (xs[i] >= BW || ys[i] >= BH) r |= 1;
      else if (b[ys[i]*BW + xs[i]]) r |= 2;
    end
    return r;
  endfunction

  task automatic model_init();
    mode = 0;
    for (int i = 0; i < 4; i++) begin
      mx[i] = 2 + i; my[i] = 0; px[i] = 0; py[i] = 0;
    end
    pd = 0; fails = 0;
    e_acc = 0; e_rej = 0; e_plc = 0; e_go = 0; e_rsn = 0;
  endtask

  task automatic model_step();
    int r;
    if (!reset) return;
    e_acc = 0; e_rej = 0; e_plc = 0; e_rsn = 0;
    case (mode)
      0: if (spawn) begin
        for (int i = 0; i < 4; i++) begin
          px[i] = int'(spawn_x[i*XW +: XW]);
          py[i] = int'(spawn_y[i*YW +: YW]);
        end
        fails = 0;
        mode = 1;
      end
      1: begin
        r = why(px, py, board_occ);
        if (r == 0) begin
          mx = px; my = py; e_acc = 1; mode = 2;
        end else begin
          e_go = 1; e_rsn = r; mode = 4;
        end
      end
      2: if (cand_valid) begin
        for (int i = 0; i < 4; i++) begin
          px[i] = int'(cand_x[i*XW +: XW]);
          py[i] = int'(cand_y[i*YW +: YW]);
        end
        pd = cand_is_down;
        mode = 3;
      end
      3: begin
        r = why(px, py, board_occ);
        mode = 2;
        if (r == 0) begin
          mx = px; my = py; e_acc = 1;
          if (pd) fails = 0;
        end else begin
          e_rej = 1; e_rsn = r;
          if (pd) begin
            fails++;
            if (fails == LD) begin
              e_plc = 1; fails = 0; mode = 0;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  always @(negedge CLK) begin
    logic [15:0] ex;
    logic [19:0] ey;
    for (int i = 0; i < 4; i++) begin
      ex[i*XW +: XW] = XW'(mx[i]);
      ey[i*YW +: YW] = YW'(my[i]);
    end
    cmp("cell_x", 32'(cell_x), 32'(ex));
    cmp("cell_y", 32'(cell_y), 32'(ey));
    cmp("accept", 32'(accept), 32'(e_acc));
    cmp("reject", 32'(reject), 32'(e_rej));
    cmp("placed", 32'(placed), 32'(e_plc));
    cmp("game_over", 32'(game_over), 32'(e_go));
    cmp("cand_ready", 32'(cand_ready), 32'(mode == 2));
    cmp("active", 32'(active), 32'(mode == 2 || mode == 3));
`ifdef REJECT_REASON_EN
    cmp("reason", 32'(reject_reason), 32'(e_rsn));
`endif
  end

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_init();
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic move(logic [15:0] x, logic [19:0] y, logic dn);
    cand_x = x; cand_y = y; cand_is_down = dn;
    cand_valid = 1'b1;
    step();
    cand_valid = 1'b0;
    step();
  endtask

  task automatic do_spawn(logic [15:0] x, logic [19:0] y);
    spawn_x = x; spawn_y = y; spawn = 1'b1;
    step();
    spawn = 1'b0;
    step();
  endtask

  initial begin
    int dx, dy;
    logic [15:0] rx;
    logic [19:0] ry;
    reset = 1'b1;
    model_init();
    #1 reset = 1'b0;
    step();
    step();
    reset = 1'b1;

    cmp("rst_cell_x", 32'(cell_x), 32'h5432);
    cmp("rst_cell_y", 32'(cell_y), 32'h0);
    cmp("rst_pulses", 32'({accept, reject, placed, game_over}), 32'h0);
    cmp("rst_ready", 32'(cand_ready), 32'h0);
    cmp("rst_active", 32'(active), 32'h0);

    do_spawn(16'h5432, 20'h0);
    cmp("spawn_acc", 32'(accept), 32'h1);
    cmp("spawn_active", 32'(active), 32'h1);
    cmp("spawn_ready", 32'(cand_ready), 32'h1);

    move(16'h6543, 20'h0, 1'b0);
    cmp("lat_acc", 32'(accept), 32'h1);
    cmp("lat_x", 32'(cell_x), 32'h6543);

    move(16'h8543, 20'h0, 1'b0);
    cmp("oob_rej", 32'(reject), 32'h1);
    cmp("oob_hold", 32'(cell_x), 32'h6543);
`ifdef REJECT_REASON_EN
    cmp("oob_rsn", 32'(reject_reason), 32'h1);
`endif

    board_occ = '0;
    board_occ[12] = 1'b1;
    move(16'h6543, 20'h08421, 1'b1);
    cmp("dn1_rej", 32'(reject), 32'h1);
    cmp("dn1_plc", 32'(placed), 32'h0);
`ifdef REJECT_REASON_EN
    cmp("dn1_rsn", 32'(reject_reason), 32'h2);
`endif
    move(16'h6543, 20'h08421, 1'b1);
    cmp("dn2_rej", 32'(reject), 32'h1);
    cmp("dn2_plc", 32'(placed), 32'h1);
    cmp("dn2_ready", 32'(cand_ready), 32'h0);
    cmp("dn2_active", 32'(active), 32'h0);

    do_spawn(16'h5432, 20'h0);
    cmp("sp2_acc", 32'(accept), 32'h1);
    move(16'h5432, 20'h08421, 1'b1);
    cmp("c1_rej", 32'(reject), 32'h1);
    board_occ = '0;
    move(16'h5432, 20'h08421, 1'b1);
    cmp("c2_acc", 32'(accept), 32'h1);
    cmp("c2_y", 32'(cell_y), 32'h08421);
    board_occ[20] = 1'b1;
    move(16'h5432, 20'h10842, 1'b1);
    cmp("c3_rej", 32'(reject), 32'h1);
    cmp("c3_noplc", 32'(placed), 32'h0);
    move(16'h5432, 20'h10842, 1'b1);
    cmp("c4_plc", 32'(placed), 32'h1);

    board_occ = '0;
    board_occ[3] = 1'b1;
    do_spawn(16'h5432, 20'h0);
    cmp("go_set", 32'(game_over), 32'h1);
    cmp("go_noacc", 32'(accept), 32'h0);
    cmp("go_hold_y", 32'(cell_y), 32'h08421);
    spawn = 1'b1;
    cand_valid = 1'b1;
    repeat (3) step();
    spawn = 1'b0;
    cand_valid = 1'b0;
    cmp("go_sticky", 32'(game_over), 32'h1);
    cmp("go_ready", 32'(cand_ready), 32'h0);
    reset = 1'b0;
    model_init();
    #1;
    cmp("go_clr", 32'(game_over), 32'h0);
    step();
    step();
    reset = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      if (c % 300 == 0) begin
        for (int k = 0; k < 128; k++)
          board_occ[k] = (k >= 112) ? ($urandom_range(0, 2) != 0)
                                    : ($urandom_range(0, 11) == 0);
      end
      if ((mode == 4 && $urandom_range(0, 7) == 0) || c % 700 == 699)
        do_reset();
      dx = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        rx[i*XW +: XW] = XW'(dx + i);
        ry[i*YW +: YW] = YW'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 9) == 0) rx[3:0] = 4'($urandom);
      spawn_x = rx;
      spawn_y = ry;
      spawn = ($urandom_range(0, 3) == 0);
      dx = int'($urandom_range(0, 2)) - 1;
      dy = ($urandom_range(0, 2) == 0) ? 0 : 1;
      for (int i = 0; i < 4; i++) begin
        rx[i*XW +: XW] = XW'(mx[i] + dx);
        ry[i*YW +: YW] = YW'(my[i] + dy);
      end
      if ($urandom_range(0, 15) == 0) ry[4:0] = 5'($urandom);
      cand_x = rx;
      cand_y = ry;
      cand_is_down = (dy == 1) || ($urandom_range(0, 15) == 0);
      cand_valid = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
